// File: rtl/fifo_flops_ext_pkg.sv
// Shared width helpers and status bundle for the extended flop FIFO.
package fifo_ext_pkg;

    // Widths never collapse to zero, so depth=1 style corner values still yield a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2_min1(depth + 32'd1);
    endfunction

    typedef struct packed {
        logic full;
        logic pndng;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_flops_ext_if.sv
// FIFO data/handshake bundle; error ports exist only when FIFO_ERR_EN is defined.
interface fifo_flops_ext_if #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8
);
    localparam int unsigned cnt_w = fifo_ext_pkg::cnt_width(depth);

    logic [width-1:0] Din;
    logic [width-1:0] Dout;
    logic             push;
    logic             pop;
    logic             full;
    logic             pndng;
    logic [cnt_w-1:0] count;
    logic             almost_full;
    logic             almost_empty;
`ifdef FIFO_ERR_EN
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    modport master (output Din, push, pop, err_clr,
                    input Dout, full, pndng, count, almost_full, almost_empty, overflow, underflow);
    modport slave  (input Din, push, pop, err_clr,
                    output Dout, full, pndng, count, almost_full, almost_empty, overflow, underflow);
`else
    modport master (output Din, push, pop,
                    input Dout, full, pndng, count, almost_full, almost_empty);
    modport slave  (input Din, push, pop,
                    output Dout, full, pndng, count, almost_full, almost_empty);
`endif
endinterface

// File: rtl/fifo_flops_ext_wrap_ptr.sv
// Modulo-depth pointer: counts 0..depth-1 and wraps by explicit compare, so any depth works.
module fifo_wrap_ptr #(
    parameter int unsigned depth = 8,
    parameter int unsigned ptr_w = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [ptr_w-1:0] ptr
);
    logic [ptr_w-1:0] ptr_r;

    // Advance on enable, wrapping from depth-1 back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= {ptr_w{1'b0}};
        end else if (en) begin
            if (ptr_r == ptr_w'(depth - 32'd1)) begin
                ptr_r <= {ptr_w{1'b0}};
            end else begin
                ptr_r <= ptr_r + ptr_w'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;
endmodule

// File: rtl/fifo_flops_ext.sv
// Single-clock show-ahead FIFO with any depth, occupancy and threshold flags.
// Optional FIFO_ERR_EN adds sticky overflow/underflow flags with err_clr.
module fifo_flops_ext
    import fifo_ext_pkg::*;
#(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 8,
    parameter int unsigned af_th = 6,
    parameter int unsigned ae_th = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_flops_ext_if.slave   bus
);
    localparam int unsigned ptr_w = ptr_width(depth);
    localparam int unsigned cnt_w = cnt_width(depth);

    logic [width-1:0] mem_r [depth];
    logic [ptr_w-1:0] rd_ptr_s;
    logic [ptr_w-1:0] wr_ptr_s;
    logic [cnt_w-1:0] count_r;
    logic [cnt_w-1:0] count_next_s;
    fifo_status_t     status_r;
    fifo_status_t     status_next_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO still takes a push when a pop frees the head in the same cycle.
    assign push_ok_s = bus.push & (~status_r.full | bus.pop);
    assign pop_ok_s  = bus.pop & status_r.pndng;

    fifo_wrap_ptr #(.depth(depth), .ptr_w(ptr_w)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_ok_s),
        .ptr (rd_ptr_s)
    );

    fifo_wrap_ptr #(.depth(depth), .ptr_w(ptr_w)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_ok_s),
        .ptr (wr_ptr_s)
    );

    // Next occupancy and the flags it implies, so flags register alongside count.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + cnt_w'(1);
            2'b01:   count_next_s = count_r - cnt_w'(1);
            default: count_next_s = count_r;
        endcase
        status_next_s.full         = (count_next_s == cnt_w'(depth));
        status_next_s.pndng        = (count_next_s != {cnt_w{1'b0}});
        status_next_s.almost_full  = (count_next_s >= cnt_w'(af_th));
        status_next_s.almost_empty = (count_next_s <= cnt_w'(ae_th));
    end

    // Occupancy and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= {cnt_w{1'b0}};
            status_r <= '{full: 1'b0, pndng: 1'b0, almost_full: 1'b0, almost_empty: 1'b1};
        end else begin
            count_r  <= count_next_s;
            status_r <= status_next_s;
        end
    end

    // Storage is not reset; a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst && push_ok_s) begin
            mem_r[wr_ptr_s] <= bus.Din;
        end
    end

    assign bus.Dout         = status_r.pndng ? mem_r[rd_ptr_s] : {width{1'b0}};
    assign bus.full         = status_r.full;
    assign bus.pndng        = status_r.pndng;
    assign bus.almost_full  = status_r.almost_full;
    assign bus.almost_empty = status_r.almost_empty;
    assign bus.count        = count_r;

`ifdef FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; a new error event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.push && status_r.full && !bus.pop) begin
                overflow_r <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (bus.pop && !status_r.pndng) begin
                underflow_r <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`endif
endmodule

// File: tb/tb_fifo_flops_ext.sv
// Bench for fifo_flops_ext: directed table, random run vs queue model, wrap and async-reset sequences.
module tb_fifo_flops_ext;
    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    fifo_flops_ext_if #(.width(16), .depth(8)) bus8 ();
    fifo_flops_ext_if #(.width(16), .depth(5)) bus5 ();

    fifo_flops_ext #(.width(16), .depth(8), .af_th(6), .ae_th(2)) dut8 (
        .clk (clk), .rst (rst), .bus (bus8.slave));
    fifo_flops_ext #(.width(16), .depth(5), .af_th(4), .ae_th(1)) dut5 (
        .clk (clk), .rst (rst), .bus (bus5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic [15:0] din;
        int          exp_cnt;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] q8[$];
    logic [15:0] q5[$];

    function automatic void add(input logic p, input logic q, input logic [15:0] d,
                                input int c, input logic [15:0] o);
        vec_t v;
        v.push = p; v.pop = q; v.din = d; v.exp_cnt = c; v.exp_dout = o;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string tag, input int cnt, input logic [15:0] dout);
        chk({tag, ".count"}, 32'(bus8.count), 32'(cnt));
        chk({tag, ".Dout"}, 32'(bus8.Dout), 32'(dout));
        chk({tag, ".full"}, 32'(bus8.full), 32'(cnt == 8));
        chk({tag, ".pndng"}, 32'(bus8.pndng), 32'(cnt != 0));
        chk({tag, ".almost_full"}, 32'(bus8.almost_full), 32'(cnt >= 6));
        chk({tag, ".almost_empty"}, 32'(bus8.almost_empty), 32'(cnt <= 2));
    endtask

    task automatic chk5(input string tag, input int cnt, input logic [15:0] dout);
        chk({tag, ".count"}, 32'(bus5.count), 32'(cnt));
        chk({tag, ".Dout"}, 32'(bus5.Dout), 32'(dout));
        chk({tag, ".full"}, 32'(bus5.full), 32'(cnt == 5));
        chk({tag, ".almost_full"}, 32'(bus5.almost_full), 32'(cnt >= 4));
        chk({tag, ".almost_empty"}, 32'(bus5.almost_empty), 32'(cnt <= 1));
        chk({tag, ".count_le_depth"}, 32'(bus5.count <= 3'd5), 32'd1);
    endtask

    task automatic step8(input logic p, input logic q, input logic [15:0] d);
        bus8.push = p; bus8.pop = q; bus8.Din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step5(input logic p, input logic q, input logic [15:0] d);
        bus5.push = p; bus5.pop = q; bus5.Din = d;
        @(posedge clk);
        #1;
    endtask

    // Reference: a pop takes the head if anything is stored; a push fits if not full or popping.
    task automatic mstep8(input string tag, input logic p, input logic q, input logic [15:0] d);
        bit pa, qa;
        qa = q && (q8.size() > 0);
        pa = p && ((q8.size() < 8) || q);
        step8(p, q, d);
        if (qa) void'(q8.pop_front());
        if (pa) q8.push_back(d);
        chk8(tag, q8.size(), (q8.size() > 0) ? q8[0] : 16'h0000);
    endtask

    task automatic mstep5(input string tag, input logic p, input logic q, input logic [15:0] d);
        bit pa, qa;
        qa = q && (q5.size() > 0);
        pa = p && ((q5.size() < 5) || q);
        step5(p, q, d);
        if (qa) void'(q5.pop_front());
        if (pa) q5.push_back(d);
        chk5(tag, q5.size(), (q5.size() > 0) ? q5[0] : 16'h0000);
    endtask

    initial begin
        rst = 1'b0;
        bus8.push = 1'b0; bus8.pop = 1'b0; bus8.Din = 16'h0000;
        bus5.push = 1'b0; bus5.pop = 1'b0; bus5.Din = 16'h0000;
`ifdef FIFO_ERR_EN
        bus8.err_clr = 1'b0;
        bus5.err_clr = 1'b0;
`endif

        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 16'(i), i, 16'h0001);
        add(1'b1, 1'b0, 16'hBEEF, 8, 16'h0001);
        for (int k = 1; k <= 8; k++) add(1'b0, 1'b1, 16'h0000, 8 - k, (k < 8) ? 16'(k + 1) : 16'h0000);
        add(1'b0, 1'b1, 16'h0000, 0, 16'h0000);
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 16'(i), i, 16'h0001);
        add(1'b1, 1'b1, 16'hAAAA, 8, 16'h0002);
        for (int k = 1; k <= 7; k++) add(1'b0, 1'b1, 16'h0000, 8 - k, (k < 7) ? 16'(k + 2) : 16'hAAAA);
        add(1'b0, 1'b1, 16'h0000, 0, 16'h0000);
        add(1'b1, 1'b1, 16'h1234, 1, 16'h1234);
        add(1'b0, 1'b1, 16'h0000, 0, 16'h0000);

        @(posedge clk);
        #1;
        chk8("reset", 0, 16'h0000);
        chk5("reset5", 0, 16'h0000);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step8(tbl[i].push, tbl[i].pop, tbl[i].din);
            chk8($sformatf("tbl%0d", i), tbl[i].exp_cnt, tbl[i].exp_dout);
        end

        // Random traffic in fill-heavy, balanced and drain-heavy phases.
        for (int i = 0; i < 300; i++) begin
            int pp, pq;
            pp = (i < 100) ? 80 : ((i < 200) ? 50 : 25);
            pq = (i < 100) ? 25 : ((i < 200) ? 50 : 80);
            mstep8("rnd", 1'($urandom_range(99) < pp), 1'($urandom_range(99) < pq), 16'($urandom));
        end

        // Depth-5 instance: fill past full, drain, then interleave so both pointers wrap.
        for (int i = 0; i < 6; i++) mstep5("d5fill", 1'b1, 1'b0, 16'h5000 + 16'(i));
        for (int i = 0; i < 3; i++) mstep5("d5drain", 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 12; i++) mstep5("d5wrap", 1'b1, (i % 3) != 0, 16'h5100 + 16'(i));
        for (int i = 0; i < 6; i++) mstep5("d5empty", 1'b0, 1'b1, 16'h0000);

        // Asynchronous reset mid-burst at count=4, with a push pending.
        while (q8.size() > 0) mstep8("pre_rst", 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 4; i++) mstep8("burst", 1'b1, 1'b0, 16'h0A00 + 16'(i));
        bus8.push = 1'b1; bus8.Din = 16'h0077;
        #3;
        rst = 1'b0;
        #1;
        chk8("async_rst", 0, 16'h0000);
        @(posedge clk);
        #1;
        chk8("rst_hold", 0, 16'h0000);
        bus8.push = 1'b0;
        #2;
        rst = 1'b1;
        q8.delete();
        mstep8("post_rst", 1'b1, 1'b0, 16'h0055);
        chk("post_rst.Dout55", 32'(bus8.Dout), 32'h0055);
        mstep8("post_rst_pop", 1'b0, 1'b1, 16'h0000);

`ifdef FIFO_ERR_EN
        bus8.err_clr = 1'b1;
        mstep8("clr", 1'b0, 1'b0, 16'h0000);
        bus8.err_clr = 1'b0;
        chk("clr.underflow", 32'(bus8.underflow), 32'd0);
        chk("clr.overflow", 32'(bus8.overflow), 32'd0);
        mstep8("uf", 1'b1, 1'b1, 16'h1234);
        chk("uf.underflow", 32'(bus8.underflow), 32'd1);
        mstep8("uf_hold", 1'b0, 1'b0, 16'h0000);
        chk("uf_hold.underflow", 32'(bus8.underflow), 32'd1);
        bus8.err_clr = 1'b1;
        mstep8("uf_clr", 1'b0, 1'b0, 16'h0000);
        bus8.err_clr = 1'b0;
        chk("uf_clr.underflow", 32'(bus8.underflow), 32'd0);
        for (int i = 0; i < 7; i++) mstep8("of_fill", 1'b1, 1'b0, 16'h0B00 + 16'(i));
        chk("of_fill.overflow", 32'(bus8.overflow), 32'd0);
        bus8.err_clr = 1'b1;
        mstep8("of_set_wins", 1'b1, 1'b0, 16'hDEAD);
        chk("of_set_wins.overflow", 32'(bus8.overflow), 32'd1);
        mstep8("of_clr", 1'b0, 1'b0, 16'h0000);
        bus8.err_clr = 1'b0;
        chk("of_clr.overflow", 32'(bus8.overflow), 32'd0);
        while (q8.size() > 0) mstep8("err_drain", 1'b0, 1'b1, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_flops_ext.md
Name: fifo_flops_ext

Overview:
Parametrised successor to the flop-based FIFO: synchronous single-clock FIFO with arbitrary (non-power-of-2) depth, occupancy count, programmable almost-full/almost-empty thresholds and defined simultaneous push/pop semantics at both boundaries. Drop-in for the existing FIFO slot: keeps Din/Dout/push/pop/full/pndng naming and adds status outputs for the driver/checker environment.

Parameters:
width, 16, data word width in bits (>=1)
depth, 8, number of storage entries (>=2, need not be a power of 2)
af_th, 6, almost_full asserted when count >= af_th (1..depth)
ae_th, 2, almost_empty asserted when count <= ae_th (0..depth-1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
Din  input  width  write data, sampled when push accepted
push  input  1  write request
pop  input  1  read request; consumes word currently on Dout
Dout  output  width  head word (show-ahead); 0 when empty
full  output  1  count == depth
pndng  output  1  count != 0 (data pending)
count  output  $clog2(depth+1)  current occupancy 0..depth
almost_full  output  1  count >= af_th
almost_empty  output  1  count <= ae_th

Behaviour:
- Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, Dout=0, full=0, pndng=0, almost_full=0, almost_empty=1; memory contents not cleared. Release takes effect on next rising edge.
- Show-ahead: Dout = mem[rd_ptr] combinationally when pndng=1, else 0. Word written at edge N visible on Dout after edge N if FIFO was empty (1-cycle write-to-read latency).
- Push accepted if push=1 and (full=0 or pop=1): mem[wr_ptr]<=Din, wr_ptr advances.
- Pop accepted if pop=1 and pndng=1: rd_ptr advances.
- Pointer wrap: pointer == depth-1 advances to 0 (explicit compare, not power-of-2 rollover).
- count: +1 push only, -1 pop only, unchanged on both or neither.
- Full + push + pop: both accepted, count stays depth, full stays 1; popped word is old head, Din stored in freed slot.
- Empty + push + pop: pop ignored, push accepted, count -> 1.
- Push on full without pop: Din dropped, no state change. Pop on empty: no state change, Dout stays 0.
- All status outputs derived from registered count (no extra cycle latency vs count).
- Reset mid-operation: immediate return to reset state; in-flight push in that cycle discarded.

Optional Feature:
FIFO_ERR_EN. Defined: adds ports err_clr (input 1), overflow (output 1), underflow (output 1). overflow sets sticky on dropped push (full, push=1, pop=0); underflow sets sticky on pop with pndng=0 (including empty push+pop). Both cleared by rst or err_clr=1 at edge; set event in same cycle as err_clr wins (flag stays 1). Not defined: ports absent, illegal ops silently ignored as above.

Decomposition:
- Package fifo_ext_pkg: function for pointer/count widths ($clog2 wrapper), typedef for status struct {full, pndng, almost_full, almost_empty}.
- One sub-module: fifo_wrap_ptr (parametrised modulo-depth pointer with enable, async active-low reset), instantiated for rd and wr pointers.

Test Plan:
- Reset then 8 pushes of 16'h0001..16'h0008, no pop -> count 1..8, almost_full at 6th push, full=1 after 8th, Dout=16'h0001 throughout.
- Full, push 16'hBEEF without pop -> dropped; 8 pops return 16'h0001..16'h0008 in order, then pndng=0, Dout=0, almost_empty=1.
- Full, push 16'hAAAA with pop same cycle -> count stays 8, Dout=16'h0002; after 7 more pops, last word out 16'hAAAA.
- Empty, push 16'h1234 with pop -> count=1, Dout=16'h1234; with FIFO_ERR_EN underflow=1 until err_clr pulse.
- depth=5 instance, 12 interleaved push/pop cycles crossing wrap twice -> data order preserved, count never exceeds 5.
- Assert rst=0 asynchronously mid-burst at count=4 -> outputs to reset values before next clock edge; post-release push 16'h0055 -> Dout=16'h0055.
